// File: rtl/egg_timer_ctrl.sv
// Kitchen egg-timer controller: mm:ss countdown with pause/resume, timed alarm,
// auto-reload of the last configured time and a built-in 1 Hz prescaler.
module egg_timer_ctrl #(
    parameter int TICK_DIV   = 5000000,
    parameter int MAX_MINS   = 99,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       cook_time,
    input  logic       start,
    input  logic       mins_inc,
    input  logic       secs_inc,
    output logic [7:0] mins_bcd,
    output logic [7:0] secs_bcd,
    output logic [2:0] state_o,
    output logic       done,
    output logic       alarm,
    output logic       led_on,
    output logic       led_en
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ALARM_SECS > 2) ? $clog2(ALARM_SECS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALM_LAST = AW'(ALARM_SECS - 1);
    localparam logic [6:0]    MINS_TOP = 7'(MAX_MINS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONFIG  = 3'd1,
        S_PAUSED  = 3'd2,
        S_RUNNING = 3'd3,
        S_ALARM   = 3'd4
    } state_t;

    state_t        state;
    logic [6:0]    mins, reload_mins;
    logic [5:0]    secs, reload_secs;
    logic [PW-1:0] presc;
    logic [AW-1:0] alarm_cnt;
    logic          start_p1, mins_inc_p1, secs_inc_p1;

    logic          start_edge, mins_edge, secs_edge, tick, time_zero, dec_zero;
    logic [6:0]    dec_mins;
    logic [5:0]    dec_secs;
    logic [PW-1:0] presc_next;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens, ones;
        tens = 4'(v / 7'd10);
        ones = 4'(v % 7'd10);
        return {tens, ones};
    endfunction

    assign start_edge = start    & ~start_p1    & enable;
    assign mins_edge  = mins_inc & ~mins_inc_p1 & enable;
    assign secs_edge  = secs_inc & ~secs_inc_p1 & enable;
    assign tick       = (presc == PRE_LAST);
    assign presc_next = tick ? '0 : presc + PW'(1);
    assign time_zero  = (mins == 7'd0) && (secs == 6'd0);

    // One-second decrement; borrow from minutes only when seconds are exhausted.
    always_comb begin
        dec_mins = mins;
        dec_secs = secs;
        if (secs != 6'd0) begin
            dec_secs = secs - 6'd1;
        end else if (mins != 7'd0) begin
            dec_mins = mins - 7'd1;
            dec_secs = 6'd59;
        end
    end
    assign dec_zero = (dec_mins == 7'd0) && (dec_secs == 6'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            mins        <= '0;
            secs        <= '0;
            reload_mins <= '0;
            reload_secs <= '0;
            presc       <= '0;
            alarm_cnt   <= '0;
            done        <= 1'b0;
            led_on      <= 1'b0;
            led_en      <= 1'b0;
            start_p1    <= 1'b0;
            mins_inc_p1 <= 1'b0;
            secs_inc_p1 <= 1'b0;
        end else begin
            start_p1    <= start;
            mins_inc_p1 <= mins_inc;
            secs_inc_p1 <= secs_inc;
            led_en      <= enable;
            done        <= 1'b0;

            if (!enable) begin
                case (state)
                    S_RUNNING: begin
                        state  <= S_PAUSED;
                        led_on <= 1'b0;
                    end
                    S_ALARM: begin
                        state  <= S_IDLE;
                        mins   <= reload_mins;
                        secs   <= reload_secs;
                        led_on <= 1'b0;
                    end
                    default: state <= state;
                endcase
            end else if (cook_time) begin
                state  <= S_CONFIG;
                presc  <= '0;
                led_on <= 1'b0;
                if (state == S_CONFIG) begin
                    if (mins_edge) mins <= (mins >= MINS_TOP) ? 7'd0 : mins + 7'd1;
                    if (secs_edge) secs <= (secs >= 6'd59) ? 6'd0 : secs + 6'd1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_edge && !time_zero) begin
                            state  <= S_RUNNING;
                            presc  <= '0;
                            led_on <= 1'b1;
                        end
                    end
                    S_CONFIG: begin
                        reload_mins <= mins;
                        reload_secs <= secs;
                        state       <= time_zero ? S_IDLE : S_PAUSED;
                    end
                    S_PAUSED: begin
                        if (start_edge) begin
                            state  <= S_RUNNING;
                            led_on <= 1'b1;
                        end
                    end
                    S_RUNNING: begin
                        // A pause request wins over a coincident tick, which is dropped.
                        if (start_edge) begin
                            state  <= S_PAUSED;
                            led_on <= 1'b0;
                        end else begin
                            presc <= presc_next;
                            if (tick) begin
                                mins <= dec_mins;
                                secs <= dec_secs;
                                if (dec_zero) begin
                                    state     <= S_ALARM;
                                    done      <= 1'b1;
                                    alarm_cnt <= '0;
                                end
                            end
                        end
                    end
                    S_ALARM: begin
                        presc <= presc_next;
                        if (start_edge || (tick && alarm_cnt == ALM_LAST)) begin
                            state  <= S_IDLE;
                            mins   <= reload_mins;
                            secs   <= reload_secs;
                            presc  <= '0;
                            led_on <= 1'b0;
                        end else if (tick) begin
                            alarm_cnt <= alarm_cnt + AW'(1);
                            led_on    <= ~led_on;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign mins_bcd = to_bcd(mins);
    assign secs_bcd = to_bcd({1'b0, secs});
    assign state_o  = state;
    assign alarm    = (state == S_ALARM);

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Scoreboard bench for egg_timer_ctrl: directed scenarios plus random stimulus
// against a seconds-level reference model of the timer.
module tb_egg_timer_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int MAX_MINS   = 99;
    localparam int ALARM_SECS = 3;

    localparam int M_IDLE = 0, M_CFG = 1, M_PAUSE = 2, M_RUN = 3, M_ALARM = 4;
    localparam bit [2:0] B_ST = 3'b100, B_MI = 3'b010, B_SI = 3'b001;

    logic       clk = 1'b0;
    logic       rst, enable, cook_time, start, mins_inc, secs_inc;
    logic [7:0] mins_bcd, secs_bcd;
    logic [2:0] state_o;
    logic       done, alarm, led_on, led_en;

    egg_timer_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .MAX_MINS  (MAX_MINS),
        .ALARM_SECS(ALARM_SECS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .cook_time(cook_time),
        .start    (start),
        .mins_inc (mins_inc),
        .secs_inc (secs_inc),
        .mins_bcd (mins_bcd),
        .secs_bcd (secs_bcd),
        .state_o  (state_o),
        .done     (done),
        .alarm    (alarm),
        .led_on   (led_on),
        .led_en   (led_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [22:0] exp;
        int          ph;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: time held as minutes/seconds, countdown done on total seconds.
    int m_state, m_min, m_sec, rl_min, rl_sec, m_pre, m_aticks;
    bit m_done, m_led, m_led_en, p_st, p_mi, p_si;

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [22:0] pack_model();
        return {bcd(m_min), bcd(m_sec), 3'(m_state), m_done, (m_state == M_ALARM), m_led, m_led_en};
    endfunction

    task automatic go_idle_reload();
        m_state = M_IDLE;
        m_min   = rl_min;
        m_sec   = rl_sec;
        m_led   = 0;
    endtask

    task automatic step(input bit r, input bit en, input bit ck, input bit st, input bit mi, input bit si);
        bit se, me, ie, tk;
        int t;
        if (r) begin
            m_state = M_IDLE; m_min = 0; m_sec = 0; rl_min = 0; rl_sec = 0;
            m_pre = 0; m_aticks = 0; m_done = 0; m_led = 0; m_led_en = 0;
            p_st = 0; p_mi = 0; p_si = 0;
            return;
        end
        se = st && !p_st && en;
        me = mi && !p_mi && en;
        ie = si && !p_si && en;
        p_st = st; p_mi = mi; p_si = si;
        m_done   = 0;
        m_led_en = en;
        tk = (m_pre == TICK_DIV - 1);
        if (!en) begin
            if (m_state == M_RUN) begin
                m_state = M_PAUSE;
                m_led   = 0;
            end else if (m_state == M_ALARM) begin
                go_idle_reload();
            end
        end else if (ck) begin
            if (m_state == M_CFG) begin
                if (me) m_min = (m_min == MAX_MINS) ? 0 : m_min + 1;
                if (ie) m_sec = (m_sec + 1) % 60;
            end
            m_state = M_CFG;
            m_pre   = 0;
            m_led   = 0;
        end else begin
            case (m_state)
                M_IDLE: if (se && (m_min * 60 + m_sec) > 0) begin
                    m_state = M_RUN; m_pre = 0; m_led = 1;
                end
                M_CFG: begin
                    rl_min  = m_min;
                    rl_sec  = m_sec;
                    m_state = (m_min * 60 + m_sec > 0) ? M_PAUSE : M_IDLE;
                end
                M_PAUSE: if (se) begin
                    m_state = M_RUN; m_led = 1;
                end
                M_RUN: begin
                    if (se) begin
                        m_state = M_PAUSE; m_led = 0;
                    end else begin
                        m_pre = (m_pre + 1) % TICK_DIV;
                        if (tk) begin
                            t = m_min * 60 + m_sec - 1;
                            m_min = t / 60;
                            m_sec = t % 60;
                            if (t == 0) begin
                                m_state = M_ALARM; m_done = 1; m_aticks = 0;
                            end
                        end
                    end
                end
                M_ALARM: begin
                    m_pre = (m_pre + 1) % TICK_DIV;
                    if (se) begin
                        go_idle_reload(); m_pre = 0;
                    end else if (tk) begin
                        m_aticks++;
                        if (m_aticks == ALARM_SECS) begin
                            go_idle_reload(); m_pre = 0;
                        end else begin
                            m_led = !m_led;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic drive(input bit r, input bit en, input bit ck, input bit st, input bit mi, input bit si, input int ph);
        exp_t e;
        @(negedge clk);
        rst = r; enable = en; cook_time = ck; start = st; mins_inc = mi; secs_inc = si;
        step(r, en, ck, st, mi, si);
        e.cyc = cyc + 1;
        e.exp = pack_model();
        e.ph  = ph;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input bit en, input bit ck, input int ph);
        for (int i = 0; i < n; i++) drive(0, en, ck, 0, 0, 0, ph);
    endtask

    task automatic press(input bit [2:0] b, input bit en, input bit ck, input int ph);
        drive(0, en, ck, b[2], b[1], b[0], ph);
        drive(0, en, ck, 0, 0, 0, ph);
    endtask

    // Monitor: compares every queued expectation that is due at this clock.
    initial begin
        exp_t        e;
        logic [22:0] act;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e   = q.pop_front();
                act = {mins_bcd, secs_bcd, state_o, done, alarm, led_on, led_en};
                vectors++;
                if (act !== e.exp)  begin
                    miscompares++;
                    $display("FAIL outputs ph%0d cyc%0d: got m=%h s=%h st=%0d done=%b alm=%b led=%b len=%b, want m=%h s=%h st=%0d done=%b alm=%b led=%b len=%b",
                             e.ph, cyc, act[22:15], act[14:7], act[6:4], act[3], act[2], act[1], act[0],
                             e.exp[22:15], e.exp[14:7], e.exp[6:4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
                end
            end
        end
    end

    initial begin
        bit ck_r;
        rst = 1; enable = 0; cook_time = 0; start = 0; mins_inc = 0; secs_inc = 0;
        step(1, 0, 0, 0, 0, 0);

        // Reset state, then configure 01:02.
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0);
        idle(2, 1, 0, 0);
        idle(1, 1, 1, 1);
        press(B_SI, 1, 1, 1);
        press(B_SI, 1, 1, 1);
        press(B_MI, 1, 1, 1);
        idle(2, 1, 0, 1);

        // Reconfigure to 00:02, run through countdown, alarm and auto-reload.
        idle(1, 1, 1, 2);
        for (int i = 0; i < 99; i++) press(B_MI, 1, 1, 2);
        idle(1, 1, 0, 2);
        press(B_ST, 1, 0, 2);
        idle(22, 1, 0, 2);

        // 01:00: one tick to 00:59, then a pause coincident with a tick, then resume.
        idle(1, 1, 1, 3);
        press(B_MI, 1, 1, 3);
        for (int i = 0; i < 58; i++) press(B_SI, 1, 1, 3);
        idle(1, 1, 0, 3);
        press(B_ST, 1, 0, 3);
        idle(6, 1, 0, 3);
        press(B_ST, 1, 0, 3);
        idle(3, 1, 0, 3);
        press(B_ST, 1, 0, 3);
        idle(10, 1, 0, 3);
        press(B_ST, 1, 0, 3);
        idle(2, 1, 0, 3);

        // Wrap limits: 99:59 -> 00:59 -> 00:00, exit to IDLE, start ignored.
        drive(1, 0, 0, 0, 0, 0, 4);
        idle(1, 1, 0, 4);
        idle(1, 1, 1, 4);
        for (int i = 0; i < 99; i++) press(B_MI, 1, 1, 4);
        for (int i = 0; i < 59; i++) press(B_SI, 1, 1, 4);
        press(B_MI, 1, 1, 4);
        press(B_SI, 1, 1, 4);
        idle(2, 1, 0, 4);
        press(B_ST, 1, 0, 4);
        idle(2, 1, 0, 4);

        // Disable while running, buttons ignored, resume, reset mid-run.
        idle(1, 1, 1, 5);
        for (int i = 0; i < 3; i++) press(B_SI, 1, 1, 5);
        idle(1, 1, 0, 5);
        press(B_ST, 1, 0, 5);
        idle(3, 1, 0, 5);
        drive(0, 0, 0, 1, 1, 1, 5);
        drive(0, 0, 0, 0, 0, 0, 5);
        drive(0, 0, 1, 1, 0, 0, 5);
        idle(2, 1, 0, 5);
        press(B_ST, 1, 0, 5);
        idle(5, 1, 0, 5);
        drive(1, 1, 0, 0, 0, 0, 5);
        drive(1, 1, 0, 0, 0, 0, 5);
        idle(3, 1, 0, 5);

        // Alarm cut short by start, and alarm aborted by disable.
        idle(1, 1, 1, 6);
        press(B_SI, 1, 1, 6);
        idle(1, 1, 0, 6);
        press(B_ST, 1, 0, 6);
        idle(4, 1, 0, 6);
        press(B_ST, 1, 0, 6);
        idle(2, 1, 0, 6);
        press(B_ST, 1, 0, 6);
        idle(6, 1, 0, 6);
        idle(2, 0, 0, 6);
        idle(2, 1, 0, 6);

        // Randomised traffic.
        ck_r = 0;
        for (int i = 0; i < 3000; i++) begin
            bit       r, en;
            bit [2:0] b;
            if ($urandom_range(0, 39) == 0) ck_r = ~ck_r;
            en   = ($urandom_range(0, 49) != 0);
            r    = ($urandom_range(0, 1499) == 0);
            b[2] = ($urandom_range(0, 9) == 0);
            b[1] = ($urandom_range(0, 2) == 0);
            b[0] = ($urandom_range(0, 2) == 0);
            drive(r, en, ck_r, b[2], b[1], b[0], 7);
        end
        idle(2, 1, 0, 8);

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
